// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer. A registered pc addresses a
// combinational instruction memory; fetched {pc, word} pairs go into a
// 2-entry buffer whose head feeds decode with a valid/ready handshake.
module fetch_ctrl #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int LAST_ADDR = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_addr,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic              busy,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] buf_pc   [2];
  logic [DATA_W-1:0] buf_data [2];
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        count_q;
  logic              full, pop, enq;

  assign full       = (count_q == 2'd2);
  assign inst_valid = (count_q != 2'd0);
  // Head is gated by valid so a flushed buffer presents zeros, as after reset.
  assign inst_pc    = inst_valid ? buf_pc[rd_ptr_q]   : '0;
  assign inst_data  = inst_valid ? buf_data[rd_ptr_q] : '0;
  assign imem_addr  = pc_q;

  // A redirect suppresses both sides of the buffer for its cycle.
  assign pop = inst_valid && inst_ready && !redir_valid;
  assign enq = (state_q == FETCH) && (!full || pop) && !redir_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and status outputs; redirect overrides every other transition
  always_comb begin
    state_d = state_q;
    busy    = (state_q == FETCH);
    halted  = (state_q == HALT);
    unique case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   if (enq && pc_q == LAST) state_d = HALT;
      HALT:    if (start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (redir_valid) state_d = (redir_addr > LAST) ? HALT : FETCH;
  end

  // Program counter: redirect load, restart from 0, or advance on enqueue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else if (redir_valid) begin
      pc_q <= redir_addr;
    end else if (state_q == IDLE && start) begin
      pc_q <= '0;
    end else if (enq && pc_q != LAST) begin
      pc_q <= pc_q + 1'b1;
    end
  end

  // Two-entry fetch buffer with flush on redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= '0;
      buf_pc[0]   <= '0;
      buf_pc[1]   <= '0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
    end else if (redir_valid) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (enq) begin
        buf_pc[wr_ptr_q]   <= pc_q;
        buf_data[wr_ptr_q] <= imem_data;
        wr_ptr_q           <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      unique case ({enq, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed sequence with a scoreboard of expected delivered pcs.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        redir_valid;
  logic [4:0]  redir_addr;
  logic [4:0]  imem_addr;
  logic [31:0] imem_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [4:0]  inst_pc;
  logic        inst_ready;
  logic        busy;
  logic        halted;

  int unsigned total  = 0;
  int unsigned passed = 0;
  logic [4:0]  exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [4:0] a);
    return 32'hA500_0000 ^ (32'(a) * 32'h0001_0203);
  endfunction

  assign imem_data = word_of(imem_addr);

  fetch_ctrl #(.ADDR_W(5), .DATA_W(32), .LAST_ADDR(30)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .redir_valid(redir_valid),
    .redir_addr(redir_addr), .imem_addr(imem_addr), .imem_data(imem_data),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .busy(busy), .halted(halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_range(input int unsigned lo, input int unsigned hi);
    for (int unsigned a = lo; a <= hi; a++) exp_q.push_back(5'(a));
  endtask

  // One clock: at negedge score any transfer about to happen, then move to posedge+1.
  task automatic tick();
    logic [4:0] e;
    @(negedge clk);
    if (inst_valid && inst_ready && !redir_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_delivery", {27'd0, inst_pc}, 32'h1F);
      end else begin
        e = exp_q.pop_front();
        chk("deliver_pc", {27'd0, inst_pc}, {27'd0, e});
        chk("deliver_data", inst_data, word_of(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Drain the scoreboard with ready high, checking one delivery per cycle.
  task automatic drain(input string tag);
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
      tick();
      n++;
    end
    chk({tag, "_timeout"}, exp_q.size(), 32'd0);
    chk({tag, "_halted"}, {31'd0, halted}, 32'd1);
    chk({tag, "_empty"}, {31'd0, inst_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; redir_valid = 1'b0; redir_addr = '0; inst_ready = 1'b0;
    #12;
    chk("rst_imem_addr", {27'd0, imem_addr}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_inst_data", inst_data, 32'd0);
    chk("rst_inst_pc", {27'd0, inst_pc}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tick(); tick();
    chk("no_fetch_wo_start", {31'd0, busy}, 32'd0);

    // Full run 0..30 with ready high
    inst_ready = 1'b1; start = 1'b1; push_range(0, 30);
    tick(); start = 1'b0;
    chk("lat_busy", {31'd0, busy}, 32'd1);
    chk("lat_imem_addr0", {27'd0, imem_addr}, 32'd0);
    chk("lat_not_valid_yet", {31'd0, inst_valid}, 32'd0);
    tick();
    chk("lat_valid", {31'd0, inst_valid}, 32'd1);
    chk("lat_pc0", {27'd0, inst_pc}, 32'd0);
    drain("run");
    start = 1'b1; tick(); start = 1'b0;
    chk("halt_to_idle", {30'd0, busy, halted}, 32'd0);

    // Backpressure: buffer fills with 0,1 and pc parks at 2
    inst_ready = 1'b0; start = 1'b1; push_range(0, 30);
    tick(); start = 1'b0;
    repeat (5) tick();
    chk("stall_valid", {31'd0, inst_valid}, 32'd1);
    chk("stall_pc", {27'd0, inst_pc}, 32'd0);
    chk("stall_data", inst_data, word_of(5'd0));
    chk("stall_imem_addr", {27'd0, imem_addr}, 32'd2);
    inst_ready = 1'b1;
    repeat (3) tick();
    inst_ready = 1'b0;
    chk("pre_redir_imem_addr", {27'd0, imem_addr}, 32'd5);
    chk("pre_redir_head", {27'd0, inst_pc}, 32'd3);

    // Redirect to 20 with two entries buffered
    redir_valid = 1'b1; redir_addr = 5'd20;
    exp_q.delete(); push_range(20, 30);
    tick(); redir_valid = 1'b0;
    chk("redir_flush", {31'd0, inst_valid}, 32'd0);
    chk("redir_imem_addr", {27'd0, imem_addr}, 32'd20);
    chk("redir_busy", {31'd0, busy}, 32'd1);
    inst_ready = 1'b1;
    tick();
    chk("redir_first_pc", {27'd0, inst_pc}, 32'd20);
    drain("redir20");

    // Redirect to 29 from HALT, then to an out-of-range target
    redir_valid = 1'b1; redir_addr = 5'd29; push_range(29, 30);
    tick(); redir_valid = 1'b0;
    tick();
    drain("redir29");
    redir_valid = 1'b1; redir_addr = 5'd31;
    tick(); redir_valid = 1'b0;
    chk("redir31_halted", {31'd0, halted}, 32'd1);
    chk("redir31_busy", {31'd0, busy}, 32'd0);
    repeat (4) tick();
    chk("redir31_nothing", {31'd0, inst_valid}, 32'd0);

    // Start and redirect together from IDLE; a later start in FETCH is ignored
    start = 1'b1; tick(); start = 1'b0;
    chk("back_to_idle", {30'd0, busy, halted}, 32'd0);
    start = 1'b1; redir_valid = 1'b1; redir_addr = 5'd10; push_range(10, 30);
    tick(); redir_valid = 1'b0;
    chk("both_imem_addr", {27'd0, imem_addr}, 32'd10);
    tick(); start = 1'b0;
    chk("both_first_pc", {27'd0, inst_pc}, 32'd10);
    drain("both");

    // Asynchronous reset mid-stream with a full buffer
    start = 1'b1; tick(); start = 1'b0;
    inst_ready = 1'b0; start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    chk("pre_arst_valid", {31'd0, inst_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, inst_valid}, 32'd0);
    chk("arst_imem_addr", {27'd0, imem_addr}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_inst_pc", {27'd0, inst_pc}, 32'd0);
    chk("arst_inst_data", inst_data, 32'd0);
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tick(); tick();
    chk("post_arst_idle", {31'd0, busy}, 32'd0);
    chk("post_arst_imem_addr", {27'd0, imem_addr}, 32'd0);
    chk("post_arst_valid", {31'd0, inst_valid}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
